vsa16_mem_responder: RTL and testbench
======================================

Name: vsa16_mem_responder

Overview:
- Memory-side responder for the VSA16 non-pipelined core: serves instruction fetches on pc/instruction and data loads/stores on addr/datain/dataout/wr.
- Owns a program-loadable instruction memory and a data memory.
- Sequences core boot: holds the core in reset during program load, prefetches word 0, then releases it.
- Tracks the core's fixed 5-cycle IF..WB rhythm and reports protocol faults (wr outside MEM, misaligned or out-of-range data access).

Parameters:
IMEM_WORDS, 64, instruction memory depth in 16-bit words (power of 2, at most 2048)
DMEM_WORDS, 64, data memory depth in 16-bit words (power of 2, at most 32768)

Ports:
clock  input  1  master clock, rising edge
rst_n  input  1  asynchronous active-low reset
prog_mode  input  1  high = loader owns imem and the core is held in reset
prog_we  input  1  imem write strobe, honoured only while in LOAD
prog_addr  input  log2(IMEM_WORDS)  imem word index
prog_data  input  16  imem write data
core_rst  output  1  active-high reset to the core
pc  input  12  core fetch byte address
instruction  output  16  registered fetch data to the core
addr  input  16  core data byte address (ALUOutput)
dataout  input  16  core store data
wr  input  1  core store strobe
datain  output  16  combinational load data to the core
fault  output  1  sticky protocol/address fault
fault_addr  output  16  addr captured at the first fault
phase  output  3  tracked core state: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB

Behaviour:
- Reset (async, rst_n low):
  - state=LOAD, core_rst=1, instruction=0, phase=0, fault=0, fault_addr=0.
  - Memory contents are not reset.
- Boot FSM:
  - LOAD: while prog_mode=1, prog_we writes imem[prog_addr]=prog_data on the edge. Exit to PREFETCH on the first edge sampling prog_mode=0.
  - PREFETCH: one cycle, core_rst=1. At its closing edge, instruction<=imem[0], core_rst<=0, phase<=0, state<=RUN.
  - RUN: core_rst=0. A rising prog_mode in RUN returns to LOAD (core_rst=1, phase=0) on the next edge. prog_we is ignored outside LOAD.
- Phase tracking in RUN: phase increments each edge and wraps 4->0. This mirrors the core exactly because both leave reset on the same edge.
- Fetch:
  - Fetch word index = pc[log2(IMEM_WORDS):1]. Upper pc bits above the index are ignored (address aliasing).
  - On every RUN edge where phase=4, instruction <= imem[index]. pc is stable from WB through MEM.
  - instruction holds its value in all other phases, so it is valid throughout IF.
  - pc[0]=1 sampled at that edge sets fault.
- Load: datain = dmem[addr[log2(DMEM_WORDS):1]], combinational, in all cycles.
- Store:
  - On a RUN edge with wr=1 and phase=3, dmem[index] <= dataout.
  - wr=1 in any other phase or state: no write, set fault.
- Address faults:
  - Any wr=1 cycle in phase 3 with addr[0]=1 sets fault and performs no write.
  - Any wr=1 cycle in phase 3 with addr >= 2*DMEM_WORDS sets fault and performs no write.
  - Loads never fault; the index wraps.
- Fault capture:
  - fault is sticky until rst_n.
  - fault_addr latches addr (or {4'd0,pc} for a fetch fault) only on the edge that first sets fault.
  - If a fetch fault and a store fault occur on the same edge, fault_addr takes the store addr.
- Simultaneous prog_mode rise and wr in RUN: the store completes if otherwise legal, then LOAD is entered.

Test Plan:
- Load imem[0..3]={ADDI R1,R0,5; SW R1,0(R0) encoding; BEQZ R0,-2; 0}, drop prog_mode:
  - core_rst deasserts 2 edges later.
  - instruction = imem[0] during the first IF.
  - phase follows 0,1,2,3,4,0.
- Store in phase 3 with wr=1, addr=0x0004, dataout=0xBEEF:
  - datain reads 0xBEEF when addr=0x0004 on any later cycle.
  - fault stays 0.
- wr=1 in phase 2, addr=0x0008:
  - dmem[4] unchanged, fault=1, fault_addr=0x0008.
  - A later legal fault leaves fault_addr=0x0008.
- Store in phase 3 with addr=0x0003: no write, fault=1, fault_addr=0x0003.
- Store in phase 3 with addr=0x0080 (DMEM_WORDS=64): no write, fault=1, fault_addr=0x0080.
- pc=0x002 at the phase-4 edge:
  - instruction=imem[1] next IF.
  - pc=0x801 at the next phase-4 edge gives fault=1, fault_addr=0x0801.
- Assert rst_n low mid-EX: core_rst=1, instruction=0, phase=0, fault=0 immediately.
- Raise prog_mode in RUN: state returns to LOAD, imem rewrites succeed, core reboots from imem[0].

Source files
------------

// File: rtl/vsa16_mem_responder_if.sv
// rtl/vsa16_mem_responder_if.sv - loader and core memory bus between the VSA16 core side and its memory responder
interface vsa16_mem_responder_if #(
  parameter int IMEM_WORDS = 64
);
  localparam int IAW = $clog2(IMEM_WORDS);

  logic           prog_mode;
  logic           prog_we;
  logic [IAW-1:0] prog_addr;
  logic [15:0]    prog_data;
  logic           core_rst;
  logic [11:0]    pc;
  logic [15:0]    instruction;
  logic [15:0]    addr;
  logic [15:0]    dataout;
  logic           wr;
  logic [15:0]    datain;
  logic           fault;
  logic [15:0]    fault_addr;
  logic [2:0]     phase;

  modport master (
    output prog_mode, prog_we, prog_addr, prog_data, pc, addr, dataout, wr,
    input  core_rst, instruction, datain, fault, fault_addr, phase
  );

  modport slave (
    input  prog_mode, prog_we, prog_addr, prog_data, pc, addr, dataout, wr,
    output core_rst, instruction, datain, fault, fault_addr, phase
  );
endinterface

// File: rtl/vsa16_mem_responder.sv
// rtl/vsa16_mem_responder.sv - imem/dmem responder with boot sequencing and phase-tracked protocol fault checks
module vsa16_mem_responder #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic                  clock,
  input  logic                  rst_n,
  vsa16_mem_responder_if.slave  bus
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [1:0] ST_LOAD     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  localparam logic [2:0] PH_MEM = 3'd3;
  localparam logic [2:0] PH_WB  = 3'd4;

  localparam logic [16:0] DMEM_LIMIT = 17'(2 * DMEM_WORDS);

  logic [15:0] imem [IMEM_WORDS];
  logic [15:0] dmem [DMEM_WORDS];

  logic [1:0]  state_q,       state_d;
  logic        core_rst_q,    core_rst_d;
  logic [15:0] instruction_q, instruction_d;
  logic [2:0]  phase_q,       phase_d;
  logic        fault_q,       fault_d;
  logic [15:0] fault_addr_q,  fault_addr_d;

  logic           imem_we;
  logic           dmem_we;
  logic           in_run;
  logic           in_mem;
  logic           addr_oor;
  logic           store_fault;
  logic           fetch_fault;
  logic [IAW-1:0] fetch_idx;
  logic [DAW-1:0] data_idx;

  // Only index bits of pc select a word; the upper bits alias by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.pc;

  assign fetch_idx = bus.pc[IAW:1];
  assign data_idx  = bus.addr[DAW:1];
  assign in_run    = (state_q == ST_RUN);
  assign in_mem    = in_run && (phase_q == PH_MEM);
  assign addr_oor  = ({1'b0, bus.addr} >= DMEM_LIMIT);

  assign store_fault = bus.wr && (!in_mem || bus.addr[0] || addr_oor);
  assign dmem_we     = bus.wr && in_mem && !bus.addr[0] && !addr_oor;
  assign fetch_fault = in_run && (phase_q == PH_WB) && bus.pc[0];

  always_comb begin
    state_d       = state_q;
    core_rst_d    = core_rst_q;
    instruction_d = instruction_q;
    phase_d       = phase_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    imem_we       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        core_rst_d = 1'b1;
        phase_d    = 3'd0;
        imem_we    = bus.prog_mode && bus.prog_we;
        if (!bus.prog_mode) begin
          state_d = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        // Core and tracker leave reset on this same edge, so phase stays locked to the core.
        instruction_d = imem[0];
        core_rst_d    = 1'b0;
        phase_d       = 3'd0;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        core_rst_d = 1'b0;
        if (phase_q == PH_WB) begin
          phase_d       = 3'd0;
          instruction_d = imem[fetch_idx];
        end else begin
          phase_d = phase_q + 3'd1;
        end
        if (bus.prog_mode) begin
          state_d    = ST_LOAD;
          core_rst_d = 1'b1;
          phase_d    = 3'd0;
        end
      end
      default: begin
        state_d    = ST_LOAD;
        core_rst_d = 1'b1;
        phase_d    = 3'd0;
      end
    endcase

    // First fault wins; a store fault outranks a fetch fault on the same edge.
    if (!fault_q && (store_fault || fetch_fault)) begin
      fault_d      = 1'b1;
      fault_addr_d = store_fault ? bus.addr : {4'd0, bus.pc};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      core_rst_q    <= 1'b1;
      instruction_q <= 16'd0;
      phase_q       <= 3'd0;
      fault_q       <= 1'b0;
      fault_addr_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      core_rst_q    <= core_rst_d;
      instruction_q <= instruction_d;
      phase_q       <= phase_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  // Memory contents deliberately survive rst_n.
  always_ff @(posedge clock) begin
    if (imem_we) begin
      imem[bus.prog_addr] <= bus.prog_data;
    end
    if (dmem_we) begin
      dmem[data_idx] <= bus.dataout;
    end
  end

  assign bus.datain      = dmem[data_idx];
  assign bus.core_rst    = core_rst_q;
  assign bus.instruction = instruction_q;
  assign bus.phase       = phase_q;
  assign bus.fault       = fault_q;
  assign bus.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_vsa16_mem_responder.sv
// tb/tb_vsa16_mem_responder.sv - directed self-checking bench for vsa16_mem_responder
module tb_vsa16_mem_responder;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  vsa16_mem_responder_if #(.IMEM_WORDS(64)) bus_if ();

  vsa16_mem_responder #(
    .IMEM_WORDS(64),
    .DMEM_WORDS(64)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic advance_to(input logic [2:0] target);
    for (int i = 0; i < 8; i++) begin
      if (bus_if.phase == target) break;
      tick();
    end
    check("advance_to_phase", {13'd0, bus_if.phase}, {13'd0, target});
  endtask

  task automatic store(input logic [2:0] ph, input logic [15:0] a, input logic [15:0] d);
    advance_to(ph);
    bus_if.wr      = 1'b1;
    bus_if.addr    = a;
    bus_if.dataout = d;
    tick();
    bus_if.wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus_if.addr = a;
    #1;
    check(tag, bus_if.datain, exp);
  endtask

  task automatic reboot();
    rst_n = 1'b0;
    #1;
    @(negedge clock);
    rst_n            = 1'b1;
    bus_if.prog_mode = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus_if.prog_mode = 1'b1;
    bus_if.prog_we   = 1'b0;
    bus_if.prog_addr = '0;
    bus_if.prog_data = 16'd0;
    bus_if.pc        = 12'd0;
    bus_if.addr      = 16'd0;
    bus_if.dataout   = 16'd0;
    bus_if.wr        = 1'b0;
    #12;
    check("rst_core_rst", {15'd0, bus_if.core_rst}, 16'd1);
    check("rst_instruction", bus_if.instruction, 16'd0);
    check("rst_phase", {13'd0, bus_if.phase}, 16'd0);
    check("rst_fault", {15'd0, bus_if.fault}, 16'd0);
    check("rst_fault_addr", bus_if.fault_addr, 16'd0);

    // Program load and boot
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.prog_we   = 1'b1;
      bus_if.prog_addr = 6'(i);
      case (i)
        0: bus_if.prog_data = 16'h2205;
        1: bus_if.prog_data = 16'hA200;
        2: bus_if.prog_data = 16'h4FFE;
        default: bus_if.prog_data = 16'h0000;
      endcase
      tick();
    end
    bus_if.prog_we   = 1'b0;
    bus_if.prog_mode = 1'b0;
    tick();
    check("prefetch_core_rst", {15'd0, bus_if.core_rst}, 16'd1);
    tick();
    check("boot_core_rst", {15'd0, bus_if.core_rst}, 16'd0);
    check("boot_instruction", bus_if.instruction, 16'h2205);
    check("boot_phase0", {13'd0, bus_if.phase}, 16'd0);
    for (int p = 1; p <= 5; p++) begin
      tick();
      check("phase_seq", {13'd0, bus_if.phase}, 16'(p % 5));
    end

    // Legal stores
    store(3'd3, 16'h0004, 16'hBEEF);
    store(3'd3, 16'h0008, 16'h5A5A);
    store(3'd3, 16'h0002, 16'h1111);
    store(3'd3, 16'h0000, 16'h2222);
    read_check("load_4", 16'h0004, 16'hBEEF);
    read_check("load_8", 16'h0008, 16'h5A5A);
    check("legal_store_fault", {15'd0, bus_if.fault}, 16'd0);

    // Store outside MEM, then a later fault must not move fault_addr
    store(3'd2, 16'h0008, 16'h1234);
    check("wr_ex_fault", {15'd0, bus_if.fault}, 16'd1);
    check("wr_ex_fault_addr", bus_if.fault_addr, 16'h0008);
    read_check("wr_ex_nowrite", 16'h0008, 16'h5A5A);
    store(3'd3, 16'h0003, 16'hDEAD);
    check("sticky_fault_addr", bus_if.fault_addr, 16'h0008);
    read_check("misalign_nowrite_a", 16'h0002, 16'h1111);

    // Async reset mid-EX
    advance_to(3'd2);
    rst_n = 1'b0;
    #1;
    check("async_core_rst", {15'd0, bus_if.core_rst}, 16'd1);
    check("async_instruction", bus_if.instruction, 16'd0);
    check("async_phase", {13'd0, bus_if.phase}, 16'd0);
    check("async_fault", {15'd0, bus_if.fault}, 16'd0);
    reboot();
    check("reboot_instruction", bus_if.instruction, 16'h2205);

    // Misaligned store
    store(3'd3, 16'h0003, 16'hDEAD);
    check("misalign_fault", {15'd0, bus_if.fault}, 16'd1);
    check("misalign_fault_addr", bus_if.fault_addr, 16'h0003);
    read_check("misalign_nowrite_b", 16'h0002, 16'h1111);

    // Out-of-range store
    reboot();
    store(3'd3, 16'h0080, 16'h3333);
    check("oor_fault", {15'd0, bus_if.fault}, 16'd1);
    check("oor_fault_addr", bus_if.fault_addr, 16'h0080);
    read_check("oor_nowrite", 16'h0000, 16'h2222);

    // Fetch path, prog_we ignored in RUN, misaligned fetch
    reboot();
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 6'd1;
    bus_if.prog_data = 16'hFFFF;
    tick();
    bus_if.prog_we = 1'b0;
    bus_if.pc      = 12'h002;
    advance_to(3'd4);
    tick();
    check("fetch_imem1", bus_if.instruction, 16'hA200);
    check("fetch_no_fault", {15'd0, bus_if.fault}, 16'd0);
    bus_if.pc = 12'h801;
    advance_to(3'd4);
    tick();
    check("fetch_fault", {15'd0, bus_if.fault}, 16'd1);
    check("fetch_fault_addr", bus_if.fault_addr, 16'h0801);
    check("fetch_alias", bus_if.instruction, 16'h2205);

    // prog_mode rise together with a legal store, then reload and reboot
    advance_to(3'd3);
    bus_if.wr        = 1'b1;
    bus_if.addr      = 16'h000A;
    bus_if.dataout   = 16'hCAFE;
    bus_if.prog_mode = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    check("reload_core_rst", {15'd0, bus_if.core_rst}, 16'd1);
    check("reload_phase", {13'd0, bus_if.phase}, 16'd0);
    read_check("reload_store_done", 16'h000A, 16'hCAFE);
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 6'd0;
    bus_if.prog_data = 16'h7777;
    tick();
    bus_if.prog_we   = 1'b0;
    bus_if.prog_mode = 1'b0;
    tick();
    check("reload_prefetch_rst", {15'd0, bus_if.core_rst}, 16'd1);
    tick();
    check("reload_run", {15'd0, bus_if.core_rst}, 16'd0);
    check("reload_instruction", bus_if.instruction, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
